// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter.
// Contents: bus widths, FSM state encoding, d_size codes, the timeout default,
// and the registered memory-command payload struct.
package mem_arb_pkg;

    localparam int unsigned ADDR_W             = 32;
    localparam int unsigned DATA_W             = 32;
    localparam int unsigned BE_W               = DATA_W / 8;
    localparam int unsigned SHIFT_W            = 5;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 255;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_FETCH = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    // funct3[1:0] access size codes
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } d_size_e;

    // Memory command held on the bus from IDLE exit until mem_ack
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } mem_cmd_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Signal bundle for the arbiter's core-side and memory-side buses.
// Modports:
//   master - arbiter view: takes core requests and memory responses,
//            drives core responses and memory requests.
//   slave  - environment view (core plus memory), the mirror image.
interface mem_arbiter_if;
    import mem_arb_pkg::*;

    // instruction fetch port
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;
    // data load/store port
    logic              d_rd;
    logic              d_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [1:0]        d_size;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;
    logic              d_err;
    logic              wait_sig;
    // memory port
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        input  if_req, if_addr, d_rd, d_wr, d_addr, d_wdata, d_size,
               mem_rdata, mem_ack,
        output if_rdata, if_ack, d_rdata, d_ack, d_err, wait_sig,
               mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport slave (
        output if_req, if_addr, d_rd, d_wr, d_addr, d_wdata, d_size,
               mem_rdata, mem_ack,
        input  if_rdata, if_ack, d_rdata, d_ack, d_err, wait_sig,
               mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering for data accesses (purely combinational).
// Ports:
//   off_i          byte offset within the word (address bits [1:0])
//   size_i         access size code (d_size_e)
//   wdata_i        LSB-justified store data
//   be_c_o         byte enables for the memory word
//   wdata_c_o      store data moved onto its byte lanes
//   rshift_c_o     right-shift amount that brings load data back to the LSBs
//   misalign_c_o   access crosses its natural alignment or uses the reserved size
module mem_lane_align
    import mem_arb_pkg::*;
(
    input  logic [1:0]         off_i,
    input  logic [1:0]         size_i,
    input  logic [DATA_W-1:0]  wdata_i,
    output logic [BE_W-1:0]    be_c_o,
    output logic [DATA_W-1:0]  wdata_c_o,
    output logic [SHIFT_W-1:0] rshift_c_o,
    output logic               misalign_c_o
);

    // Enables and alignment check per size
    always_comb begin
        be_c_o       = '0;
        misalign_c_o = 1'b0;
        case (size_i)
            SZ_BYTE: be_c_o = BE_W'(4'b0001 << off_i);
            SZ_HALF: begin
                be_c_o       = BE_W'(4'b0011 << off_i);
                misalign_c_o = off_i[0];
            end
            SZ_WORD: begin
                be_c_o       = BE_W'(4'b1111);
                misalign_c_o = (off_i != 2'b00);
            end
            default: misalign_c_o = 1'b1;
        endcase
    end

    assign rshift_c_o = {off_i, 3'b000};
    assign wdata_c_o  = wdata_i << rshift_c_o;

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between an instruction-fetch port and a
// load/store port. Data requests win over fetches when both are pending.
// Misaligned data accesses complete immediately with d_err and never reach
// memory.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   if_req/if_addr              fetch request (held until if_ack)
//   if_rdata/if_ack             fetched word and one-cycle completion pulse
//   d_rd/d_wr/d_addr/d_wdata/d_size   load/store request (held until d_ack)
//   d_rdata/d_ack/d_err         LSB-justified load data, completion, error
//   wait_sig                    combinational core stall
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be   registered memory command
//   mem_rdata/mem_ack           memory response
// Build option: define MEM_ARB_TIMEOUT_EN to abort a memory access after
// TIMEOUT_CYCLES cycles without mem_ack (returns zero data, d_err on the data
// path). Without it the arbiter waits for mem_ack indefinitely.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [1:0]        d_size,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              d_err,
    output logic              wait_sig,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [BE_W-1:0]   mem_be,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    arb_state_e         state_q, state_d;
    mem_cmd_t           cmd_q, cmd_d;
    logic               mem_req_q, mem_req_d;
    logic [SHIFT_W-1:0] rshift_q, rshift_d;
    logic [DATA_W-1:0]  if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]  d_rdata_q, d_rdata_d;
    logic               if_ack_q, if_ack_d;
    logic               d_ack_q, d_ack_d;
    logic               d_err_q, d_err_d;

    logic [BE_W-1:0]    lane_be_c;
    logic [DATA_W-1:0]  lane_wdata_c;
    logic [SHIFT_W-1:0] lane_rshift_c;
    logic               misalign_c;
    logic               timeout_c;

    // Lane steering of the live data request
    mem_lane_align u_lane_align (
        .off_i        (d_addr[1:0]),
        .size_i       (d_size),
        .wdata_i      (d_wdata),
        .be_c_o       (lane_be_c),
        .wdata_c_o    (lane_wdata_c),
        .rshift_c_o   (lane_rshift_c),
        .misalign_c_o (misalign_c)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    // Cycles spent waiting for mem_ack; fires on the last permitted cycle
    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             busy_c;

    assign busy_c    = (state_q == ST_DATA) || (state_q == ST_FETCH);
    assign timeout_c = busy_c && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_d = '0;
        if (busy_c && !timeout_c) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign timeout_c = 1'b0;
`endif

    // Fetch addresses are word-aligned; low bits and the limit may go unused
    logic unused_c;
    assign unused_c = ^{if_addr[1:0], 32'(TIMEOUT_CYCLES)};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, memory command and response values
    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        cmd_d      = cmd_q;
        rshift_d   = rshift_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if_ack_d   = 1'b0;
        d_ack_d    = 1'b0;
        d_err_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (d_rd || d_wr) begin
                    if (misalign_c) begin
                        state_d   = ST_RESP;
                        d_ack_d   = 1'b1;
                        d_err_d   = 1'b1;
                        d_rdata_d = '0;
                    end else begin
                        state_d     = ST_DATA;
                        mem_req_d   = 1'b1;
                        cmd_d.we    = d_wr;
                        cmd_d.addr  = {d_addr[ADDR_W-1:2], 2'b00};
                        cmd_d.wdata = lane_wdata_c;
                        cmd_d.be    = lane_be_c;
                        rshift_d    = lane_rshift_c;
                    end
                end else if (if_req) begin
                    state_d     = ST_FETCH;
                    mem_req_d   = 1'b1;
                    cmd_d.we    = 1'b0;
                    cmd_d.addr  = {if_addr[ADDR_W-1:2], 2'b00};
                    cmd_d.wdata = '0;
                    cmd_d.be    = '1;
                end
            end
            ST_DATA: begin
                if (mem_ack) begin
                    state_d   = ST_RESP;
                    mem_req_d = 1'b0;
                    d_ack_d   = 1'b1;
                    d_rdata_d = mem_rdata >> rshift_q;
                end else if (timeout_c) begin
                    state_d   = ST_RESP;
                    mem_req_d = 1'b0;
                    d_ack_d   = 1'b1;
                    d_err_d   = 1'b1;
                    d_rdata_d = '0;
                end
            end
            ST_FETCH: begin
                if (mem_ack) begin
                    state_d    = ST_RESP;
                    mem_req_d  = 1'b0;
                    if_ack_d   = 1'b1;
                    if_rdata_d = mem_rdata;
                end else if (timeout_c) begin
                    state_d    = ST_RESP;
                    mem_req_d  = 1'b0;
                    if_ack_d   = 1'b1;
                    if_rdata_d = '0;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q      <= '0;
            mem_req_q  <= 1'b0;
            rshift_q   <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            d_err_q    <= 1'b0;
        end else begin
            cmd_q      <= cmd_d;
            mem_req_q  <= mem_req_d;
            rshift_q   <= rshift_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            if_ack_q   <= if_ack_d;
            d_ack_q    <= d_ack_d;
            d_err_q    <= d_err_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = cmd_q.we;
    assign mem_addr  = cmd_q.addr;
    assign mem_wdata = cmd_q.wdata;
    assign mem_be    = cmd_q.be;
    assign if_rdata  = if_rdata_q;
    assign if_ack    = if_ack_q;
    assign d_rdata   = d_rdata_q;
    assign d_ack     = d_ack_q;
    assign d_err     = d_err_q;

    // Stall while any request is pending and not being acknowledged
    assign wait_sig = (d_rd | d_wr | if_req) & ~(d_ack_q | if_ack_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// load/store/fetch traffic, compared against a byte-level reference model.
// Honours MEM_ARB_TIMEOUT_EN (DUT built with TIMEOUT_CYCLES = 4).
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;
    logic [31:0] hold_d;
    logic [31:0] hold_if;

    mem_arbiter_if bus();

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (bus.if_req),
        .if_addr   (bus.if_addr),
        .if_rdata  (bus.if_rdata),
        .if_ack    (bus.if_ack),
        .d_rd      (bus.d_rd),
        .d_wr      (bus.d_wr),
        .d_addr    (bus.d_addr),
        .d_wdata   (bus.d_wdata),
        .d_size    (bus.d_size),
        .d_rdata   (bus.d_rdata),
        .d_ack     (bus.d_ack),
        .d_err     (bus.d_err),
        .wait_sig  (bus.wait_sig),
        .mem_req   (bus.mem_req),
        .mem_we    (bus.mem_we),
        .mem_addr  (bus.mem_addr),
        .mem_wdata (bus.mem_wdata),
        .mem_be    (bus.mem_be),
        .mem_rdata (bus.mem_rdata),
        .mem_ack   (bus.mem_ack)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model (byte-lane view) ----------------
    function automatic int nbytes(input logic [1:0] sz);
        case (sz)
            2'b00:   return 1;
            2'b01:   return 2;
            2'b10:   return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit model_misaligned(input logic [1:0] sz, input logic [1:0] off);
        int nb = nbytes(sz);
        if (nb == 0) return 1'b1;
        return (int'(off) % nb) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [1:0] off);
        logic [3:0] be = '0;
        int o = int'(off);
        for (int i = 0; i < 4; i++)
            if (i >= o && i < o + nbytes(sz)) be[i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] wd, input logic [1:0] off);
        logic [31:0] r = '0;
        int o = int'(off);
        for (int i = 0; i < 4; i++)
            if (i >= o) r[8*i +: 8] = wd[8*(i-o) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_rdata(input logic [31:0] md, input logic [1:0] off);
        logic [31:0] r = '0;
        int o = int'(off);
        for (int j = 0; j < 4; j++)
            if (j + o < 4) r[8*j +: 8] = md[8*(j+o) +: 8];
        return r;
    endfunction

    // ---------------- transactions ----------------
    task automatic data_txn(input string tg, input bit wr, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [1:0] sz,
                            input logic [31:0] md, input int dly, input bit with_if);
        logic [1:0] off = addr[1:0];
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        bus.d_rd = !wr; bus.d_wr = wr; bus.d_addr = addr; bus.d_wdata = wd; bus.d_size = sz;
        if (with_if) bus.if_req = 1'b1;
        @(negedge clk);
        check({tg, ".wait_req"}, 32'(bus.wait_sig), 32'd1);
        check({tg, ".req_idle"}, 32'(bus.mem_req), 32'd0);
        if (model_misaligned(sz, off)) begin
            @(negedge clk);
            check({tg, ".mis_ack"}, 32'(bus.d_ack), 32'd1);
            check({tg, ".mis_err"}, 32'(bus.d_err), 32'd1);
            check({tg, ".mis_rdata"}, bus.d_rdata, 32'd0);
            check({tg, ".mis_noreq"}, 32'(bus.mem_req), 32'd0);
            check({tg, ".mis_wait"}, 32'(bus.wait_sig), 32'd0);
            hold_d = '0;
        end else begin
            @(negedge clk);
            check({tg, ".req"}, 32'(bus.mem_req), 32'd1);
            check({tg, ".addr"}, bus.mem_addr, {addr[31:2], 2'b00});
            check({tg, ".we"}, 32'(bus.mem_we), 32'(wr));
            check({tg, ".be"}, 32'(bus.mem_be), 32'(model_be(sz, off)));
            check({tg, ".wdata"}, bus.mem_wdata, model_wdata(wd, off));
            check({tg, ".wait_busy"}, 32'(bus.wait_sig), 32'd1);
            repeat (dly) begin
                @(negedge clk);
                check({tg, ".req_hold"}, 32'(bus.mem_req), 32'd1);
                check({tg, ".no_ack"}, 32'(bus.d_ack), 32'd0);
            end
            bus.mem_ack = 1'b1; bus.mem_rdata = md;
            @(posedge clk); #1;
            bus.mem_ack = 1'b0; bus.mem_rdata = $urandom;
            @(negedge clk);
            check({tg, ".ack"}, 32'(bus.d_ack), 32'd1);
            check({tg, ".err"}, 32'(bus.d_err), 32'd0);
            check({tg, ".rdata"}, bus.d_rdata, model_rdata(md, off));
            check({tg, ".req_drop"}, 32'(bus.mem_req), 32'd0);
            check({tg, ".wait_ack"}, 32'(bus.wait_sig), 32'd0);
            check({tg, ".if_ack"}, 32'(bus.if_ack), 32'd0);
            hold_d = model_rdata(md, off);
        end
        @(posedge clk); #1;
        bus.d_rd = 1'b0; bus.d_wr = 1'b0;
        @(negedge clk);
        check({tg, ".ack_pulse"}, 32'(bus.d_ack), 32'd0);
        check({tg, ".err_clr"}, 32'(bus.d_err), 32'd0);
        check({tg, ".rdata_hold"}, bus.d_rdata, hold_d);
        check({tg, ".req_after"}, 32'(bus.mem_req), 32'd0);
        check({tg, ".wait_after"}, 32'(bus.wait_sig), 32'(with_if));
    endtask

    // pending=1: if_req already seen by IDLE in the current cycle
    task automatic fetch_txn(input string tg, input logic [31:0] addr,
                             input logic [31:0] md, input int dly, input bit pending);
        if (!pending) begin
            @(posedge clk); #1;
            bus.mem_ack = 1'b0;
            bus.if_req = 1'b1; bus.if_addr = addr;
            @(negedge clk);
            check({tg, ".wait_req"}, 32'(bus.wait_sig), 32'd1);
            check({tg, ".req_idle"}, 32'(bus.mem_req), 32'd0);
        end
        @(negedge clk);
        check({tg, ".req"}, 32'(bus.mem_req), 32'd1);
        check({tg, ".addr"}, bus.mem_addr, {bus.if_addr[31:2], 2'b00});
        check({tg, ".we"}, 32'(bus.mem_we), 32'd0);
        check({tg, ".be"}, 32'(bus.mem_be), 32'hF);
        repeat (dly) begin
            @(negedge clk);
            check({tg, ".req_hold"}, 32'(bus.mem_req), 32'd1);
            check({tg, ".no_ack"}, 32'(bus.if_ack), 32'd0);
        end
        bus.mem_ack = 1'b1; bus.mem_rdata = md;
        @(posedge clk); #1;
        bus.mem_ack = 1'b0; bus.mem_rdata = $urandom;
        @(negedge clk);
        check({tg, ".ack"}, 32'(bus.if_ack), 32'd1);
        check({tg, ".rdata"}, bus.if_rdata, md);
        check({tg, ".d_ack"}, 32'(bus.d_ack), 32'd0);
        check({tg, ".d_err"}, 32'(bus.d_err), 32'd0);
        check({tg, ".wait_ack"}, 32'(bus.wait_sig), 32'd0);
        hold_if = md;
        @(posedge clk); #1;
        bus.if_req = 1'b0;
        @(negedge clk);
        check({tg, ".ack_pulse"}, 32'(bus.if_ack), 32'd0);
        check({tg, ".rdata_hold"}, bus.if_rdata, hold_if);
        check({tg, ".d_hold"}, bus.d_rdata, hold_d);
        check({tg, ".wait_after"}, 32'(bus.wait_sig), 32'd0);
    endtask

    // Idle cycles, optionally with stray mem_ack pulses that must be ignored
    task automatic idle_cycles(input int n, input bit stray);
        repeat (n) begin
            @(posedge clk); #1;
            bus.mem_ack = 1'b0;
            @(negedge clk);
            check("idle.req", 32'(bus.mem_req), 32'd0);
            check("idle.acks", 32'({bus.d_ack, bus.if_ack, bus.d_err}), 32'd0);
            check("idle.wait", 32'(bus.wait_sig), 32'd0);
            bus.mem_ack = stray && ($urandom_range(0, 1) == 1);
            bus.mem_rdata = $urandom;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, w, m;
        int kind;
        rst_n = 1'b0;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_rd = 1'b0; bus.d_wr = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_size = '0;
        bus.mem_rdata = '0; bus.mem_ack = 1'b0;
        hold_d = '0; hold_if = '0;

        // reset values
        @(negedge clk);
        check("rst.mem_req", 32'(bus.mem_req), 32'd0);
        check("rst.acks", 32'({bus.d_ack, bus.if_ack, bus.d_err}), 32'd0);
        check("rst.mem_addr", bus.mem_addr, 32'd0);
        check("rst.mem_be", 32'(bus.mem_be), 32'd0);
        check("rst.d_rdata", bus.d_rdata, 32'd0);
        check("rst.if_rdata", bus.if_rdata, 32'd0);
        check("rst.wait", 32'(bus.wait_sig), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // store byte at 0x103, ack one cycle after mem_req
        data_txn("SB", 1'b1, 32'h0000_0103, 32'h0000_00AB, SZ_BYTE, 32'h5555_5555, 1, 1'b0);
        // load half at 0x202
        data_txn("LH", 1'b0, 32'h0000_0202, 32'h0, SZ_HALF, 32'h1234_ABCD, 0, 1'b0);
        check("LH.value", bus.d_rdata, 32'h0000_1234);
        // simultaneous load and fetch: data first, then fetch
        bus.if_addr = 32'h0000_0604;
        data_txn("SIMD", 1'b0, 32'h0000_0500, 32'h0, SZ_WORD, 32'hCAFE_F00D, 1, 1'b1);
        fetch_txn("SIMF", 32'h0000_0604, 32'h0BAD_BEEF, 0, 1'b1);
        // misaligned word load
        data_txn("LW", 1'b0, 32'h0000_0201, 32'h0, SZ_WORD, 32'h0, 0, 1'b0);
        // plain fetch, then a stray ack while idle
        fetch_txn("IF", 32'h0000_1000, 32'h0000_0013, 2, 1'b0);
        idle_cycles(3, 1'b1);

        // reset asserted mid-transaction
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        bus.d_rd = 1'b1; bus.d_addr = 32'h0000_0300; bus.d_size = SZ_WORD;
        @(negedge clk);
        @(negedge clk);
        check("RST.req_before", 32'(bus.mem_req), 32'd1);
        #1 rst_n = 1'b0; bus.mem_ack = 1'b1;
        #1;
        check("RST.req_now", 32'(bus.mem_req), 32'd0);
        check("RST.addr_now", bus.mem_addr, 32'd0);
        check("RST.if_rdata", bus.if_rdata, 32'd0);
        bus.d_rd = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; bus.mem_ack = 1'b0;
        hold_d = '0; hold_if = '0;
        idle_cycles(1, 1'b0);
        data_txn("POSTRST", 1'b1, 32'h0000_0302, 32'h0000_BEEF, SZ_HALF, 32'h0, 0, 1'b0);

        // memory that never acknowledges
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        bus.d_rd = 1'b1; bus.d_addr = 32'h0000_0400; bus.d_size = SZ_WORD;
        @(negedge clk);
`ifdef MEM_ARB_TIMEOUT_EN
        repeat (4) begin
            @(negedge clk);
            check("TMO.req_hold", 32'(bus.mem_req), 32'd1);
            check("TMO.no_ack", 32'(bus.d_ack), 32'd0);
        end
        @(negedge clk);
        check("TMO.req_drop", 32'(bus.mem_req), 32'd0);
        check("TMO.ack", 32'(bus.d_ack), 32'd1);
        check("TMO.err", 32'(bus.d_err), 32'd1);
        check("TMO.rdata", bus.d_rdata, 32'd0);
        hold_d = '0;
`else
        repeat (12) begin
            @(negedge clk);
            check("NOTMO.req_hold", 32'(bus.mem_req), 32'd1);
            check("NOTMO.no_ack", 32'(bus.d_ack), 32'd0);
        end
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h7654_3210;
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        @(negedge clk);
        check("NOTMO.ack", 32'(bus.d_ack), 32'd1);
        check("NOTMO.err", 32'(bus.d_err), 32'd0);
        check("NOTMO.rdata", bus.d_rdata, 32'h7654_3210);
        hold_d = 32'h7654_3210;
`endif
        @(posedge clk); #1;
        bus.d_rd = 1'b0;
        @(negedge clk);
        check("TMO.ack_pulse", 32'(bus.d_ack), 32'd0);

        // random traffic
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 2);
            a = $urandom; w = $urandom; m = $urandom;
            if (kind == 2)
                fetch_txn("RND_IF", a, m, $urandom_range(0, 2), 1'b0);
            else
                data_txn(kind == 1 ? "RND_ST" : "RND_LD", kind == 1, a, w,
                         2'($urandom_range(0, 3)), m, $urandom_range(0, 2), 1'b0);
            idle_cycles($urandom_range(0, 2), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the memory-ack wait limit in cycles (used only with MEM_ARB_TIMEOUT_EN).
REQ-002 SHALL have ports exactly as follows:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- if_req  input  1  instruction-fetch request, held until if_ack.
- if_addr  input  32  fetch address, word-aligned.
- if_rdata  output  32  fetched word, valid with if_ack.
- if_ack  output  1  one-cycle fetch completion pulse.
- d_rd  input  1  data load request (executor read_data_sig).
- d_wr  input  1  data store request (executor write_data_sig).
- d_addr  input  32  data byte address.
- d_wdata  input  32  store data, LSB-justified.
- d_size  input  2  funct3[1:0]: 00 byte, 01 half, 10 word.
- d_rdata  output  32  load data, LSB-justified, not extended (executor extends).
- d_ack  output  1  one-cycle data completion pulse.
- d_err  output  1  error flag, valid with d_ack.
- wait_sig  output  1  core stall.
- mem_req  output  1  memory request, held until mem_ack.
- mem_we  output  1  1 = write.
- mem_addr  output  32  word address (byte address with [1:0] = 0).
- mem_wdata  output  32  lane-shifted write data.
- mem_be  output  4  byte enables.
- mem_rdata  input  32  memory read word.
- mem_ack  input  1  memory completion, one cycle.

Function
REQ-003 SHALL implement FSM states IDLE, DATA, FETCH, RESP.
REQ-004 In IDLE, d_rd|d_wr SHALL select DATA, else if_req SHALL select FETCH; data has fixed priority over fetch on simultaneous requests.
REQ-005 SHALL drive mem_req, mem_we, mem_addr, mem_wdata and mem_be from registers loaded on the IDLE exit edge, held constant until mem_ack.
REQ-006 On mem_ack in DATA or FETCH, SHALL capture rdata and go to RESP; the ack pulses high in RESP for exactly one cycle; RESP then returns to IDLE.
REQ-007 Latency: request present in IDLE cycle N gives mem_req high in N+1; mem_ack in cycle M gives ack in M+1.
REQ-008 Byte enables SHALL be: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111. mem_wdata SHALL be d_wdata<<(8*addr[1:0]).
REQ-009 d_rdata SHALL be mem_rdata>>(8*addr[1:0]); fetch data SHALL be unshifted.
REQ-010 Misaligned accesses (half with addr[0]=1, word with addr[1:0]!=0, or d_size=11) SHALL go directly IDLE->RESP with no mem_req, and SHALL produce d_ack with d_err=1 and d_rdata=0.
REQ-011 wait_sig SHALL equal (d_rd|d_wr|if_req) & ~(d_ack|if_ack), combinationally.
REQ-012 mem_ack outside DATA/FETCH SHALL be ignored.
REQ-013 A request still asserted in the IDLE cycle after RESP SHALL be treated as a new request.
REQ-014 Unused acks and d_err SHALL be 0 outside RESP; if_rdata and d_rdata SHALL hold their last value.

Reset
REQ-015 rst_n low SHALL immediately force IDLE and zero all outputs and registers, including mid-transaction; an in-flight mem_ack is lost.

Configuration
REQ-016 With MEM_ARB_TIMEOUT_EN defined, a counter SHALL run in DATA/FETCH; after TIMEOUT_CYCLES cycles without mem_ack, the block SHALL drop mem_req and go to RESP, returning rdata=0 and d_err=1 (data path) or if_rdata=0 (fetch path).
REQ-017 Without MEM_ARB_TIMEOUT_EN, the block SHALL wait for mem_ack indefinitely, d_err SHALL indicate misalignment only, and no counter logic SHALL exist.

Structure
REQ-018 Package mem_arb_pkg SHALL hold the FSM state encoding, the d_size codes and the TIMEOUT_CYCLES default.
REQ-019 The combinational sub-module mem_lane_align SHALL compute mem_be, mem_wdata, the read shift and the misalign flag.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- SB: d_addr=0x103, d_wdata=0xAB, mem_ack one cycle after mem_req -> mem_addr=0x100, mem_be=1000, mem_wdata=0xAB000000, d_ack 1 cycle, wait_sig low after.
- LH: d_addr=0x202, mem_rdata=0x1234ABCD -> d_rdata=0x00001234, d_err=0.
- d_rd and if_req asserted in the same cycle -> data transaction first; fetch mem_req starts only after d_ack, then if_ack.
- LW at 0x201 -> no mem_req, d_ack with d_err=1 two cycles after request.
- rst_n low while mem_req=1 -> mem_req=0 immediately; IDLE after release.
- MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, mem_ack never asserted -> mem_req drops, d_ack with d_err=1; without the macro, mem_req stays high.
